sdram_init_refresh: RTL and testbench
=====================================

Name: sdram_init_refresh

Overview:
- Upstream sequencing stage for the SDRAM controller: power-up initialisation and the periodic auto-refresh schedule.
- Issues SDRAM commands through a valid/ack handshake. The controller executes each command on its SDRAM pins.
- Runs on MEMCLK. Defers refreshes while a Zorro II RAM cycle is in flight and raises an urgent flag when the backlog is full.

Parameters:
- INIT_WAIT, 14200, MEMCLK cycles of power-up wait before the first command (≥200 µs)
- REFRESH_INTERVAL, 1100, MEMCLK cycles between refresh requests (≤15.6 µs)
- INIT_REFRESHES, 8, auto-refreshes issued during initialisation
- MAX_PENDING, 7, saturation value of the refresh backlog counter (3-bit)
- T_RP, 3, wait cycles after PRECHARGE_ALL ack
- T_RFC, 7, wait cycles after AUTO_REFRESH ack
- T_MRD, 2, wait cycles after LOAD_MODE ack
- MODE_VALUE, 12'h020, mode register word (CAS latency 2, burst length 1)

Ports:
- MEMCLK  in  1  clock
- RESET_n  in  1  asynchronous active-low reset
- bus_idle  in  1  high when the Z2 state machine is idle and no RAM cycle is pending
- cmd_ack  in  1  controller has issued the presented command this cycle
- cmd_valid  out  1  command request
- cmd_code  out  2  00 NOP, 01 PRECHARGE_ALL, 10 AUTO_REFRESH, 11 LOAD_MODE
- mode_value  out  12  MODE_VALUE, constant
- cke  out  1  SDRAM clock enable
- init_done  out  1  initialisation complete; RAM cycles permitted
- refresh_urgent  out  1  backlog equals MAX_PENDING
- refresh_overrun  out  1  sticky flag: a tick arrived while the backlog was saturated

Behaviour:
- Reset (asynchronous): state=INIT_WAIT and all counters are 0.
  - Outputs: cmd_valid=0, cmd_code=00, cke=0, init_done=0, refresh_urgent=0, refresh_overrun=0.
- cke=1 from the first MEMCLK edge after reset deassertion.
- Handshake:
  - cmd_valid and cmd_code are registered and held stable until cmd_ack is sampled high on a rising edge.
  - cmd_valid=0 and cmd_code=00 on the following cycle.
  - A request is never retracted, even if bus_idle falls.
  - cmd_ack while cmd_valid=0 is ignored.
- States:
  - INIT_WAIT: count INIT_WAIT cycles, then go to PRE.
  - PRE: request PRECHARGE_ALL; on ack go to WAIT_RP (T_RP cycles), then INIT_REF.
  - INIT_REF: request AUTO_REFRESH; on ack wait T_RFC cycles and increment the init count. After INIT_REFRESHES acks go to LMR, otherwise repeat.
  - LMR: request LOAD_MODE; on ack wait T_MRD cycles, then RUN with init_done=1 from that edge.
  - bus_idle is ignored during initialisation.
  - RUN:
    - Interval counter counts 0..REFRESH_INTERVAL-1 and wraps. The wrap is a tick. The counter starts at 0 on entry to RUN.
    - Tick increments the backlog, saturating at MAX_PENDING. A tick while saturated sets refresh_overrun; it clears only on reset.
    - When backlog>0, no request is outstanding, not in the T_RFC wait, and bus_idle=1: assert AUTO_REFRESH request.
    - On ack: decrement the backlog and wait T_RFC cycles. Further requests are blocked during the wait; ticks still count.
    - Tick and ack on the same edge: backlog unchanged.
    - refresh_urgent = (backlog==MAX_PENDING), registered.
- init_done never falls except on reset.
- Reset mid-operation, including with an outstanding request: immediate return to reset values and a full re-initialisation.

Test Plan:
- INIT_WAIT=10, T_RP=3, T_RFC=7, T_MRD=2, INIT_REFRESHES=8, cmd_ack one cycle after each cmd_valid rise:
  - first cmd_valid (code 01) appears 10 cycles after reset release
  - then eight code-10 requests spaced 1+7 cycles
  - then code 11
  - init_done rises 2 cycles after the code-11 ack
- Hold cmd_ack low for 20 cycles during PRE -> cmd_valid=1 and code 01 stay stable; the sequence proceeds only after ack.
- RUN with REFRESH_INTERVAL=50 and bus_idle=0 for 400 cycles:
  - backlog saturates at 7 after 350 cycles and refresh_urgent=1
  - the tick at cycle 400 sets refresh_overrun
  - no cmd_valid is asserted
- Then bus_idle=1 with immediate acks -> seven code-10 requests each separated by ≥8 cycles; refresh_urgent falls after the first ack; refresh_overrun stays 1.
- Force a tick on the same edge as a refresh ack with backlog=2 -> backlog remains 2.
- Assert RESET_n low during the INIT_REF phase with cmd_valid=1 -> cmd_valid, cke and init_done drop asynchronously; after release the full sequence restarts from INIT_WAIT.

Source files
------------

// File: rtl/sdram_init_refresh_if.sv
// Command handshake between the init/refresh sequencer and the SDRAM controller.
interface sdram_init_refresh_if;
  logic        cmd_valid;
  logic        cmd_ack;
  logic [1:0]  cmd_code;
  logic [11:0] mode_value;

  modport master (output cmd_valid, cmd_code, mode_value, input cmd_ack);
  modport slave  (input cmd_valid, cmd_code, mode_value, output cmd_ack);
endinterface

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up initialisation sequence and periodic auto-refresh scheduler
// with a saturating refresh backlog deferred while the Z2 bus is busy.
module sdram_init_refresh #(
  parameter int          INIT_WAIT        = 14200,
  parameter int          REFRESH_INTERVAL = 1100,
  parameter int          INIT_REFRESHES   = 8,
  parameter int          MAX_PENDING      = 7,
  parameter int          T_RP             = 3,
  parameter int          T_RFC            = 7,
  parameter int          T_MRD            = 2,
  parameter logic [11:0] MODE_VALUE       = 12'h020
) (
  input  logic                        MEMCLK,
  input  logic                        RESET_n,
  input  logic                        bus_idle,
  sdram_init_refresh_if.master        cmd,
  output logic                        cke,
  output logic                        init_done,
  output logic                        refresh_urgent,
  output logic                        refresh_overrun
);
  localparam int W1   = (INIT_WAIT > T_RFC) ? INIT_WAIT : T_RFC;
  localparam int W2   = (T_RP > T_MRD) ? T_RP : T_MRD;
  localparam int WMAX = (W1 > W2) ? W1 : W2;
  localparam int CW   = $clog2(WMAX + 1);
  localparam int IW   = $clog2(REFRESH_INTERVAL + 1);
  localparam int NW   = $clog2(INIT_REFRESHES + 1);
  localparam int BW   = $clog2(MAX_PENDING + 1);

  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_PRE = 2'b01;
  localparam logic [1:0] C_REF = 2'b10;
  localparam logic [1:0] C_LMR = 2'b11;

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_PRE, S_WAIT_RP, S_INIT_REF, S_WAIT_RFC, S_LMR, S_WAIT_MRD, S_RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] icnt;
  logic [NW-1:0] init_cnt;
  logic [BW-1:0] backlog, backlog_nxt;
  logic          in_rfc;
  logic          ack, tick, rfc_done;

  assign cmd.mode_value = MODE_VALUE;
  assign ack      = cmd.cmd_valid & cmd.cmd_ack;
  assign tick     = (state == S_RUN) && (icnt == IW'(REFRESH_INTERVAL - 1));
  assign rfc_done = in_rfc && (cnt == CW'(T_RFC - 1));

  // A tick and an ack on the same edge cancel out.
  always_comb begin
    backlog_nxt = backlog;
    if (state == S_RUN) begin
      if (tick && !ack) begin
        if (backlog != BW'(MAX_PENDING)) backlog_nxt = backlog + BW'(1);
      end else if (ack && !tick) begin
        backlog_nxt = backlog - BW'(1);
      end
    end
  end

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state           <= S_INIT_WAIT;
      cnt             <= '0;
      icnt            <= '0;
      init_cnt        <= '0;
      backlog         <= '0;
      in_rfc          <= 1'b0;
      cmd.cmd_valid   <= 1'b0;
      cmd.cmd_code    <= C_NOP;
      cke             <= 1'b0;
      init_done       <= 1'b0;
      refresh_urgent  <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      cke <= 1'b1;
      if (ack) begin
        cmd.cmd_valid <= 1'b0;
        cmd.cmd_code  <= C_NOP;
      end
      case (state)
        S_INIT_WAIT:
          if (cnt == CW'(INIT_WAIT - 1)) begin
            cnt           <= '0;
            state         <= S_PRE;
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_code  <= C_PRE;
          end else cnt <= cnt + CW'(1);
        S_PRE:
          if (ack) state <= S_WAIT_RP;
        S_WAIT_RP:
          if (cnt == CW'(T_RP - 1)) begin
            cnt           <= '0;
            state         <= S_INIT_REF;
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_code  <= C_REF;
          end else cnt <= cnt + CW'(1);
        S_INIT_REF:
          if (ack) begin
            init_cnt <= init_cnt + NW'(1);
            state    <= S_WAIT_RFC;
          end
        S_WAIT_RFC:
          if (cnt == CW'(T_RFC - 1)) begin
            cnt           <= '0;
            cmd.cmd_valid <= 1'b1;
            if (init_cnt == NW'(INIT_REFRESHES)) begin
              state        <= S_LMR;
              cmd.cmd_code <= C_LMR;
            end else begin
              state        <= S_INIT_REF;
              cmd.cmd_code <= C_REF;
            end
          end else cnt <= cnt + CW'(1);
        S_LMR:
          if (ack) state <= S_WAIT_MRD;
        S_WAIT_MRD:
          if (cnt == CW'(T_MRD - 1)) begin
            cnt       <= '0;
            icnt      <= '0;
            state     <= S_RUN;
            init_done <= 1'b1;
          end else cnt <= cnt + CW'(1);
        S_RUN: begin
          icnt <= tick ? '0 : icnt + IW'(1);
          if (tick && backlog == BW'(MAX_PENDING)) refresh_overrun <= 1'b1;
          if (ack) begin
            in_rfc <= 1'b1;
            cnt    <= '0;
          end else if (in_rfc) begin
            if (rfc_done) in_rfc <= 1'b0;
            else          cnt    <= cnt + CW'(1);
          end
          // The request may go out on the edge that closes the tRFC window.
          if (!cmd.cmd_valid && (!in_rfc || rfc_done) && backlog != '0 && bus_idle) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_code  <= C_REF;
          end
        end
        default: state <= S_INIT_WAIT;
      endcase
      backlog        <= backlog_nxt;
      refresh_urgent <= (backlog_nxt == BW'(MAX_PENDING));
    end
  end
endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench: init sequence timing, held request, async reset restart,
// refresh backlog saturation/overrun, deferred drain and tick/ack coincidence.
module tb_sdram_init_refresh;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bus_idle = 1'b0;
  logic cke, init_done, urgent, overrun;
  int   edges;
  int   n_chk = 0;
  int   n_err = 0;

  sdram_init_refresh_if cmd_if ();

  sdram_init_refresh #(.INIT_WAIT(10), .REFRESH_INTERVAL(50)) dut (
    .MEMCLK          (clk),
    .RESET_n         (rst_n),
    .bus_idle        (bus_idle),
    .cmd             (cmd_if),
    .cke             (cke),
    .init_done       (init_done),
    .refresh_urgent  (urgent),
    .refresh_overrun (overrun)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request, check its edge and code, optionally ack it.
  task automatic wait_req(input string tag, input int code, input int exp_edge, input bit do_ack);
    int t = 0;
    while (!cmd_if.cmd_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_seen"}, int'(cmd_if.cmd_valid), 1);
    chk({tag, "_edge"}, edges, exp_edge);
    chk({tag, "_code"}, int'(cmd_if.cmd_code), code);
    if (do_ack) begin
      cmd_if.cmd_ack = 1'b1;
      @(negedge clk);
      cmd_if.cmd_ack = 1'b0;
      chk({tag, "_drop"}, int'(cmd_if.cmd_valid), 0);
    end
  endtask

  initial begin
    int r, nv, stable;
    cmd_if.cmd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(cmd_if.cmd_valid), 0);
    chk("rst_code", int'(cmd_if.cmd_code), 0);
    chk("rst_cke", int'(cke), 0);
    chk("rst_done", int'(init_done), 0);
    chk("rst_urgent", int'(urgent), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cke_up", int'(cke), 1);

    // Phase 1: held PRECHARGE_ALL, then reset while an INIT_REF request is up.
    wait_req("pre_a", 1, 10, 1'b0);
    stable = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_code === 2'b01)) stable++;
    end
    chk("pre_hold", stable, 0);
    cmd_if.cmd_ack = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ack = 1'b0;
    chk("pre_a_drop", int'(cmd_if.cmd_valid), 0);
    wait_req("iref_a0", 2, 34, 1'b1);
    wait_req("iref_a1", 2, 42, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(cmd_if.cmd_valid), 0);
    chk("mid_rst_code", int'(cmd_if.cmd_code), 0);
    chk("mid_rst_cke", int'(cke), 0);
    chk("mid_rst_done", int'(init_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Phase 2: full init with prompt acks; bus_idle low must not matter.
    wait_req("pre", 1, 10, 1'b1);
    for (int k = 0; k < 8; k++)
      wait_req($sformatf("iref%0d", k), 2, 14 + 8 * k, 1'b1);
    chk("done_pre_lmr", int'(init_done), 0);
    wait_req("lmr", 3, 78, 1'b1);
    chk("mode_value", int'(cmd_if.mode_value), 32);
    @(negedge clk);
    chk("done_80", int'(init_done), 0);
    @(negedge clk);
    chk("done_81", int'(init_done), 1);
    r = edges;

    // RUN, bus busy: backlog saturates, overrun; stray acks ignored.
    nv = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      cmd_if.cmd_ack = (i >= 100 && i < 104);
      if (cmd_if.cmd_valid) nv++;
      if (i == 349) chk("urgent_349", int'(urgent), 0);
      if (i == 350) chk("urgent_350", int'(urgent), 1);
      if (i == 399) chk("overrun_399", int'(overrun), 0);
      if (i == 400) chk("overrun_400", int'(overrun), 1);
    end
    cmd_if.cmd_ack = 1'b0;
    chk("busy_no_req", nv, 0);

    // Drain five, then line up one ack with the tick at r+450.
    bus_idle = 1'b1;
    wait_req("run0", 2, r + 401, 1'b1);
    chk("urgent_fall", int'(urgent), 0);
    chk("overrun_sticky", int'(overrun), 1);
    for (int j = 1; j < 5; j++)
      wait_req($sformatf("run%0d", j), 2, r + 401 + 8 * j, 1'b1);
    bus_idle = 1'b0;
    nv = 0;
    while (edges < r + 448) begin
      @(negedge clk);
      if (cmd_if.cmd_valid) nv++;
    end
    chk("defer_no_req", nv, 0);
    bus_idle = 1'b1;
    wait_req("coinc", 2, r + 449, 1'b1);
    wait_req("post0", 2, r + 457, 1'b1);
    wait_req("post1", 2, r + 465, 1'b1);
    wait_req("next_tick", 2, r + 501, 1'b1);
    chk("overrun_end", int'(overrun), 1);
    chk("done_end", int'(init_done), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
